// File: rtl/phase_scheduler.sv
// Programmable two-phase non-overlapping clock-enable sequencer with valid/ready config port.
// Optional completed-cycle counter enabled by defining PHASE_SCHED_COUNT_EN.
module phase_scheduler #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic             cfg_err,
  input  logic             run_req,
  output logic             run_ack,
  output logic [1:0]       phase,
  output logic             cycle_done,
  output logic [15:0]      cycle_count
);

  typedef enum logic [2:0] {IDLE, PH0, GAP0, PH1, GAP1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic [CNT_W-1:0] g_q, g_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_accept, cfg_legal, dwell_end;

  always_comb begin
    cfg_accept = cfg_valid && (state_q == IDLE);
    cfg_legal  = (cfg_width != '0) && (cfg_gap != '0);
    dwell_end  = (cnt_q == CNT_W'(1));

    w_d       = w_q;
    g_d       = g_q;
    cfg_err_d = cfg_accept && !cfg_legal;
    if (cfg_accept && cfg_legal) begin
      w_d = cfg_width;
      g_d = cfg_gap;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A legal word accepted on the start edge already sets the first PH0 dwell.
        if (run_req) begin
          state_d = PH0;
          cnt_d   = w_d;
        end
      end
      PH0: begin
        if (dwell_end) begin
          state_d = GAP0;
          cnt_d   = g_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP0: begin
        if (dwell_end) begin
          state_d = PH1;
          cnt_d   = w_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PH1: begin
        if (dwell_end) begin
          state_d = GAP1;
          cnt_d   = g_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP1: begin
        if (dwell_end) begin
          if (run_req) begin
            state_d = PH0;
            cnt_d   = w_q;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      w_q       <= CNT_W'(1);
      g_q       <= CNT_W'(1);
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      g_q       <= g_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_ready  = (state_q == IDLE);
  assign run_ack    = (state_q != IDLE);
  assign phase      = {state_q == PH1, state_q == PH0};
  assign cycle_done = (state_q == GAP1) && dwell_end;
  assign cfg_err    = cfg_err_q;

`ifdef PHASE_SCHED_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (cycle_done) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign cycle_count = count_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_phase_scheduler.sv
// Randomized bench for phase_scheduler, checked against a position-in-period reference model.
module tb_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_width;
  logic [7:0]  cfg_gap;
  logic        cfg_err;
  logic        run_req;
  logic        run_ack;
  logic [1:0]  phase;
  logic        cycle_done;
  logic [15:0] cycle_count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: running flag plus position t within one 2*(W+G) period.
  int m_running, m_t, m_w, m_g, m_err, m_count;

  phase_scheduler #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_err(cfg_err),
    .run_req(run_req), .run_ack(run_ack), .phase(phase),
    .cycle_done(cycle_done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int period();
    return 2 * (m_w + m_g);
  endfunction

  function automatic int exp_phase();
    if (!m_running) return 0;
    if (m_t < m_w) return 1;
    if (m_t < m_w + m_g) return 0;
    if (m_t < 2 * m_w + m_g) return 2;
    return 0;
  endfunction

  function automatic int exp_done();
    return (m_running != 0 && m_t == period() - 1) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int done_now;
    if (!rst_n) begin
      m_running = 0; m_t = 0; m_w = 1; m_g = 1; m_err = 0; m_count = 0;
      return;
    end
    done_now = exp_done();
    m_err = 0;
    if (!m_running && cfg_valid) begin
      if (cfg_width != 0 && cfg_gap != 0) begin
        m_w = int'(cfg_width);
        m_g = int'(cfg_gap);
      end else begin
        m_err = 1;
      end
    end
    if (!m_running) begin
      if (run_req) begin m_running = 1; m_t = 0; end
    end else if (done_now != 0) begin
`ifdef PHASE_SCHED_COUNT_EN
      m_count = (m_count + 1) % 65536;
`endif
      if (run_req) m_t = 0;
      else m_running = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_eq("phase", 32'(phase), 32'(exp_phase()));
      check_eq("run_ack", 32'(run_ack), 32'(m_running));
      check_eq("cfg_ready", 32'(cfg_ready), 32'(m_running == 0));
      check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
      check_eq("cycle_done", 32'(cycle_done), 32'(exp_done()));
      check_eq("cycle_count", 32'(cycle_count), 32'(m_count));
      check_eq("no_overlap", 32'(phase == 2'b11), 32'(0));
    end
  endtask

  task automatic cfg(input int w, input int g);
    cfg_valid = 1'b1;
    cfg_width = 8'(w);
    cfg_gap   = 8'(g);
  endtask

  initial begin
    m_running = 0; m_t = 0; m_w = 1; m_g = 1; m_err = 0; m_count = 0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_width = '0; cfg_gap = '0; run_req = 1'b0;
    @(negedge clk);
    step(2);
    rst_n = 1'b1;

    // Default W=1,G=1 free run, then stop.
    run_req = 1'b1; step(20);
    run_req = 1'b0; step(6);

    // W=3,G=2; drop run_req mid-PH1 of third period.
    cfg(3, 2); step(1); cfg_valid = 1'b0;
    run_req = 1'b1; step(1 + 20 + 6);
    run_req = 1'b0; step(12);

    // Illegal word in IDLE, then run on old W/G.
    cfg(0, 5); step(1); cfg_valid = 1'b0;
    run_req = 1'b1; step(8);
    run_req = 1'b0; step(12);

    // Illegal word together with start.
    cfg(4, 0); run_req = 1'b1; step(1); cfg_valid = 1'b0;
    step(5); run_req = 1'b0; step(12);

    // Legal word together with start.
    cfg(2, 4); run_req = 1'b1; step(1); cfg_valid = 1'b0;
    step(20); run_req = 1'b0; step(14);

    // cfg_valid held while running is ignored.
    run_req = 1'b1; step(1);
    cfg(7, 7); step(10); cfg_valid = 1'b0;
    run_req = 1'b0; step(14);

    // Reset in the middle of PH0.
    cfg(5, 1); run_req = 1'b1; step(1); cfg_valid = 1'b0;
    step(2);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1; run_req = 1'b0; step(2);

    // Five periods at W=G=1 from reset.
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    run_req = 1'b1; step(21);
`ifdef PHASE_SCHED_COUNT_EN
    check_eq("count_5", 32'(cycle_count), 32'd5);
`else
    check_eq("count_tied", 32'(cycle_count), 32'd0);
`endif
    run_req = 1'b0; step(6);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_width = 8'($urandom_range(0, 4));
      cfg_gap   = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) run_req = ~run_req;
      step(1);
    end
    rst_n = 1'b1; cfg_valid = 1'b0; run_req = 1'b0;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
